bsr32_seq: RTL



---
 rtl/bsr32_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/bsr32_seq.sv
// Sequential bit-scan-reverse: index of the most-significant set bit of an operand (x86 BSR).
// Latency: k = 1..NCH scan cycles after accept (early exit on first non-zero slice from MSB end).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one bubble per op.
module bsr32_seq #(
  parameter int WIDTH = 32,  // operand width, power of 2, multiple of CHUNK
  parameter int CHUNK = 8    // bits examined per scan cycle, power of 2, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic                     out_v
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int NCH  = WIDTH / CHUNK;
  // Slice pointer width; kept at least one bit so a single-slice build still elaborates.
  localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
  // Bit position within a slice.
  localparam int CW   = $clog2(CHUNK);

  localparam logic [PW-1:0] PTR_TOP = PW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state;
  // Operand viewed as NCH slices so the active slice is a plain array select.
  logic [NCH-1:0][CHUNK-1:0]  op;
  logic [PW-1:0]              ptr;

  logic [CHUNK-1:0]           slice;
  logic                       slice_nz;
  logic [CW-1:0]              slice_pos;

  assign slice    = op[ptr];
  assign slice_nz = |slice;

  // Priority encoder: position of the highest set bit inside the active slice.
  always_comb begin
    slice_pos = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (slice[i]) slice_pos = CW'(i);
    end
  end

  // Control FSM with registered handshake outputs and result.
  // Because CHUNK and NCH are powers of two, the absolute index is the
  // concatenation {slice pointer, position in slice}; it can never overflow IDXW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_v     <= 1'b0;
      op        <= '0;
      ptr       <= PTR_TOP;
    end else begin
      case (state)
        IDLE: begin
          // Operand is only sampled on a handshake, so X outside it never reaches state.
          if (in_valid && in_ready) begin
            op       <= in_data;
            ptr      <= PTR_TOP;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (slice_nz) begin
            out_idx   <= IDXW'({ptr, slice_pos});
            out_v     <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (ptr == '0) begin
            // Whole operand is zero: index is reported as 0 with out_v low (ZF=1).
            out_idx   <= '0;
            out_v     <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end
        DONE: begin
          // No same-cycle accept: returning to IDLE first keeps the input path simple.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
